// File: rtl/rom_fetch_scheduler_pkg.sv
`timescale 1ns/1ps
// Shared constants and types for the column-index ROM fetch scheduler.
// The defaults here describe the SpMV build: four column FIFOs fed from a
// single 13-bit-addressed ROM port.
package rom_fetch_scheduler_pkg;

  localparam int unsigned CHANNEL_NUM     = 4;
  localparam int unsigned COL_ID_SIZE     = 13;
  localparam int unsigned COL_FIFO_DEPTH  = 16;
  localparam int unsigned COL_ROM_LATENCY = 1;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_RUN   = 2'd1,
    ST_DRAIN = 2'd2,
    ST_DONE  = 2'd3
  } fetch_state_e;

  // Channel index that follows idx on a ring of ch channels.
  function automatic int unsigned ring_next(input int unsigned idx, input int unsigned ch);
    return (idx + 32'd1 >= ch) ? 32'd0 : idx + 32'd1;
  endfunction

endpackage

// File: rtl/rom_fetch_scheduler_chk.sv
`timescale 1ns/1ps
// Protocol checks for the fetch scheduler, kept apart from the datapath.
module rom_fetch_scheduler_chk
  import rom_fetch_scheduler_pkg::*;
#(
  parameter int unsigned CH = CHANNEL_NUM
) (
  input logic          clk,
  input logic          rst,
  input logic [CH-1:0] fifo_rd_i,
  input logic [CH-1:0] cred_full_i,
  input logic [CH-1:0] gnt_i,
  input logic [CH-1:0] fifo_wr_en_i
);

  // A pop into a full credit counter with no matching grant means a consumer
  // popped a FIFO that the scheduler believes is empty.
  credit_overflow_a: assert property (@(posedge clk) disable iff (rst)
    (fifo_rd_i & cred_full_i & ~gnt_i) == '0);

  // Only one FIFO is written per cycle.
  wr_onehot_a: assert property (@(posedge clk) disable iff (rst)
    $onehot0(fifo_wr_en_i));

endmodule

// File: rtl/rom_fetch_scheduler_rr_arbiter.sv
`timescale 1ns/1ps
// Rotating-priority arbiter: scans the request vector starting at ptr_i and
// wraps around, granting the first requester it meets. Purely combinational;
// the owner keeps the pointer register.
module rom_fetch_scheduler_rr_arbiter
  import rom_fetch_scheduler_pkg::*;
#(
  parameter int unsigned CH    = CHANNEL_NUM,
  parameter int unsigned IDX_W = (CH > 1) ? $clog2(CH) : 1
) (
  input  logic [CH-1:0]    req_i,
  input  logic [IDX_W-1:0] ptr_i,
  output logic [CH-1:0]    gnt_o,
  output logic [IDX_W-1:0] gnt_idx_o,
  output logic             gnt_vld_o
);

  // Walk the ring from the pointer; only the first hit takes the grant.
  always_comb begin
    logic [IDX_W-1:0] cand;
    logic             take;
    gnt_o     = '0;
    gnt_idx_o = '0;
    gnt_vld_o = 1'b0;
    cand      = '0;
    take      = 1'b0;
    for (int unsigned off = 0; off < CH; off++) begin
      cand         = IDX_W'((32'(ptr_i) + off) % CH);
      take         = req_i[cand] & ~gnt_vld_o;
      gnt_o[cand]  = take;
      gnt_idx_o    = take ? cand : gnt_idx_o;
      gnt_vld_o    = gnt_vld_o | take;
    end
  end

endmodule

// File: rtl/rom_fetch_scheduler.sv
`timescale 1ns/1ps
// Shares one column-index ROM port among CH column FIFOs for an SpMV pass.
// Each channel walks [start, end); one read is issued per cycle round-robin,
// gated by a per-FIFO credit counter so in-flight reads can never overflow.
module rom_fetch_scheduler
  import rom_fetch_scheduler_pkg::*;
#(
  parameter int unsigned CH          = CHANNEL_NUM,
  parameter int unsigned ADDR_W      = COL_ID_SIZE,
  parameter int unsigned FIFO_DEPTH  = COL_FIFO_DEPTH,
  parameter int unsigned ROM_LATENCY = COL_ROM_LATENCY
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 start,
  input  logic [ADDR_W*CH-1:0] start_addr,
  input  logic [ADDR_W*CH-1:0] end_addr,
  input  logic [CH-1:0]        fifo_rd,
  output logic [ADDR_W-1:0]    rom_addr,
  output logic [CH-1:0]        fifo_wr_en,
  output logic                 busy,
  output logic                 done
);

  localparam int unsigned IDX_W  = (CH > 1) ? $clog2(CH) : 1;
  localparam int unsigned CRED_W = $clog2(FIFO_DEPTH + 1);

  fetch_state_e      state_q, state_d;
  logic [ADDR_W-1:0] cur_q [CH];
  logic [ADDR_W-1:0] cur_d [CH];
  logic [ADDR_W-1:0] end_q [CH];
  logic [ADDR_W-1:0] end_d [CH];
  logic [CRED_W-1:0] credit_q [CH];
  logic [CRED_W-1:0] credit_d [CH];
  logic [IDX_W-1:0]  ptr_q, ptr_d;
  logic              pipe_vld_q [ROM_LATENCY];
  logic              pipe_vld_d [ROM_LATENCY];
  logic [IDX_W-1:0]  pipe_idx_q [ROM_LATENCY];
  logic [IDX_W-1:0]  pipe_idx_d [ROM_LATENCY];
  logic [ADDR_W-1:0] rom_addr_q, rom_addr_d;
  logic [CH-1:0]     fifo_wr_en_q, fifo_wr_en_d;
  logic              busy_q, busy_d;
  logic              done_q, done_d;

  logic [CH-1:0]     req_s;
  logic [CH-1:0]     gnt_s;
  logic [CH-1:0]     cred_full_s;
  logic [IDX_W-1:0]  gnt_idx_s;
  logic              gnt_vld_s;
  logic              all_done_s;
  logic              inflight_s;

  // Per-channel eligibility and pass-level status from registered state only.
  always_comb begin
    req_s       = '0;
    cred_full_s = '0;
    all_done_s  = 1'b1;
    inflight_s  = 1'b0;
    for (int i = 0; i < CH; i++) begin
      req_s[i]       = (state_q == ST_RUN) && (cur_q[i] != end_q[i]) && (credit_q[i] != '0);
      cred_full_s[i] = (credit_q[i] == CRED_W'(FIFO_DEPTH));
      all_done_s     = all_done_s & (cur_q[i] == end_q[i]);
    end
    for (int j = 0; j < ROM_LATENCY; j++) begin
      inflight_s = inflight_s | pipe_vld_q[j];
    end
  end

  rom_fetch_scheduler_rr_arbiter #(
    .CH    (CH),
    .IDX_W (IDX_W)
  ) u_arb (
    .req_i     (req_s),
    .ptr_i     (ptr_q),
    .gnt_o     (gnt_s),
    .gnt_idx_o (gnt_idx_s),
    .gnt_vld_o (gnt_vld_s)
  );

  // Next-state: issue, credit bookkeeping, latency pipe and pass sequencing.
  always_comb begin
    state_d    = state_q;
    cur_d      = cur_q;
    end_d      = end_q;
    credit_d   = credit_q;
    busy_d     = busy_q;
    done_d     = 1'b0;

    // Credits: pop returns one, grant consumes one, both together cancel.
    for (int i = 0; i < CH; i++) begin
      case ({fifo_rd[i], gnt_s[i]})
        2'b10:   credit_d[i] = cred_full_s[i] ? credit_q[i] : credit_q[i] + CRED_W'(1);
        2'b01:   credit_d[i] = credit_q[i] - CRED_W'(1);
        default: credit_d[i] = credit_q[i];
      endcase
    end

    // Issue: the granted channel's address goes to the ROM and advances.
    if (gnt_vld_s) begin
      cur_d[gnt_idx_s] = cur_q[gnt_idx_s] + ADDR_W'(1);
      rom_addr_d       = cur_q[gnt_idx_s];
      ptr_d            = IDX_W'(ring_next(32'(gnt_idx_s), CH));
    end else begin
      rom_addr_d       = rom_addr_q;
      ptr_d            = ptr_q;
    end

    // Stage 0 lines up with rom_addr; the last stage drives the write strobe.
    pipe_vld_d[0] = gnt_vld_s;
    pipe_idx_d[0] = gnt_idx_s;
    for (int j = 1; j < ROM_LATENCY; j++) begin
      pipe_vld_d[j] = pipe_vld_q[j-1];
      pipe_idx_d[j] = pipe_idx_q[j-1];
    end
    fifo_wr_en_d = '0;
    if (pipe_vld_q[ROM_LATENCY-1]) begin
      fifo_wr_en_d[pipe_idx_q[ROM_LATENCY-1]] = 1'b1;
    end else begin
      fifo_wr_en_d = '0;
    end

    case (state_q)
      ST_IDLE: begin
        if (start) begin
          for (int i = 0; i < CH; i++) begin
            cur_d[i] = start_addr[i*ADDR_W +: ADDR_W];
            end_d[i] = end_addr[i*ADDR_W +: ADDR_W];
          end
          busy_d  = 1'b1;
          state_d = ST_RUN;
        end else begin
          state_d = ST_IDLE;
        end
      end
      ST_RUN: begin
        if (all_done_s) begin
          state_d = ST_DRAIN;
        end else begin
          state_d = ST_RUN;
        end
      end
      ST_DRAIN: begin
        if (!inflight_s) begin
          state_d = ST_DONE;
          done_d  = 1'b1;
          busy_d  = 1'b0;
        end else begin
          state_d = ST_DRAIN;
        end
      end
      ST_DONE: begin
        state_d = ST_IDLE;
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  // State and output registers; reset aborts any pass in progress.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q      <= ST_IDLE;
      ptr_q        <= '0;
      rom_addr_q   <= '0;
      fifo_wr_en_q <= '0;
      busy_q       <= 1'b0;
      done_q       <= 1'b0;
      for (int i = 0; i < CH; i++) begin
        cur_q[i]    <= '0;
        end_q[i]    <= '0;
        credit_q[i] <= CRED_W'(FIFO_DEPTH);
      end
      for (int j = 0; j < ROM_LATENCY; j++) begin
        pipe_vld_q[j] <= 1'b0;
        pipe_idx_q[j] <= '0;
      end
    end else begin
      state_q      <= state_d;
      ptr_q        <= ptr_d;
      rom_addr_q   <= rom_addr_d;
      fifo_wr_en_q <= fifo_wr_en_d;
      busy_q       <= busy_d;
      done_q       <= done_d;
      cur_q        <= cur_d;
      end_q        <= end_d;
      credit_q     <= credit_d;
      pipe_vld_q   <= pipe_vld_d;
      pipe_idx_q   <= pipe_idx_d;
    end
  end

  assign rom_addr   = rom_addr_q;
  assign fifo_wr_en = fifo_wr_en_q;
  assign busy       = busy_q;
  assign done       = done_q;

  rom_fetch_scheduler_chk #(
    .CH (CH)
  ) u_chk (
    .clk          (clk),
    .rst          (rst),
    .fifo_rd_i    (fifo_rd),
    .cred_full_i  (cred_full_s),
    .gnt_i        (gnt_s),
    .fifo_wr_en_i (fifo_wr_en_q)
  );

endmodule

// File: tb/tb_rom_fetch_scheduler.sv
`timescale 1ns/1ps
// Directed bench for rom_fetch_scheduler with CH=4, FIFO_DEPTH=16, ROM_LATENCY=1.
module tb_rom_fetch_scheduler;

  localparam int CH = 4;
  localparam int AW = 13;

  logic             clk;
  logic             rst;
  logic             start;
  logic [AW*CH-1:0] start_addr;
  logic [AW*CH-1:0] end_addr;
  logic [CH-1:0]    fifo_rd;
  logic [CH-1:0]    manual_rd;
  logic             auto_pop;
  logic [AW-1:0]    rom_addr;
  logic [CH-1:0]    fifo_wr_en;
  logic             busy;
  logic             done;

  int checks   = 0;
  int failures = 0;

  // Monitor state: written only by the monitor process.
  int          wr_cnt [CH];
  int          occ [CH];
  int          done_cnt = 0;
  int          occ_err  = 0;
  int unsigned addr_log [$];
  logic [AW-1:0] prev_addr;

  int unsigned exp_rr   [12] = '{0, 3, 6, 9, 1, 4, 7, 10, 2, 5, 8, 11};
  int unsigned exp_skip [6]  = '{100, 300, 400, 101, 301, 401};

  // A consumer model that pops each word as soon as it lands, or manual pops.
  assign fifo_rd = auto_pop ? fifo_wr_en : manual_rd;

  rom_fetch_scheduler #(
    .CH          (CH),
    .ADDR_W      (AW),
    .FIFO_DEPTH  (16),
    .ROM_LATENCY (1)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .start      (start),
    .start_addr (start_addr),
    .end_addr   (end_addr),
    .fifo_rd    (fifo_rd),
    .rom_addr   (rom_addr),
    .fifo_wr_en (fifo_wr_en),
    .busy       (busy),
    .done       (done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Logs each written word with the address the ROM saw one cycle earlier,
  // and tracks FIFO occupancy to catch any overflow.
  always @(negedge clk) begin
    if (rst) begin
      prev_addr = '0;
      for (int i = 0; i < CH; i++) occ[i] = 0;
    end else begin
      for (int i = 0; i < CH; i++) begin
        if (fifo_wr_en[i]) begin
          wr_cnt[i]++;
          addr_log.push_back(32'(prev_addr));
        end
        occ[i] = occ[i] + (fifo_wr_en[i] ? 1 : 0) - (fifo_rd[i] ? 1 : 0);
        if (occ[i] > 16 || occ[i] < 0) occ_err++;
      end
      if (done) done_cnt++;
      prev_addr = rom_addr;
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "bench timeout");
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic set_ranges(input int s0, input int e0, input int s1, input int e1,
                            input int s2, input int e2, input int s3, input int e3);
    start_addr = {13'(s3), 13'(s2), 13'(s1), 13'(s0)};
    end_addr   = {13'(e3), 13'(e2), 13'(e1), 13'(e0)};
  endtask

  task automatic pulse_start();
    start = 1'b1;
    tick();
    start = 1'b0;
  endtask

  task automatic wait_done(input int budget, output int k);
    k = 0;
    while (done !== 1'b1 && k < budget) begin
      tick();
      k++;
    end
  endtask

  initial begin
    int k;
    int base;
    int d0;
    int wb [CH];

    rst = 1'b1; start = 1'b0; start_addr = '0; end_addr = '0;
    manual_rd = '0; auto_pop = 1'b0;
    tick(); tick();
    check("rst_rom_addr", 32'(rom_addr), 0);
    check("rst_wr_en", 32'(fifo_wr_en), 0);
    check("rst_busy", 32'(busy), 0);
    check("rst_done", 32'(done), 0);
    rst = 1'b0;
    tick();

    // Four 3-word ranges interleave round-robin.
    set_ranges(0, 3, 3, 6, 6, 9, 9, 12);
    base = addr_log.size(); wb = wr_cnt; d0 = done_cnt;
    pulse_start();
    check("t1_busy", 32'(busy), 1);
    wait_done(100, k);
    check("t1_done_latency", k, 14);
    check("t1_busy_at_done", 32'(busy), 0);
    tick();
    check("t1_done_one_cycle", 32'(done), 0);
    check("t1_nwords", addr_log.size() - base, 12);
    for (int i = 0; i < 12; i++) check("t1_addr", addr_log[base+i], exp_rr[i]);
    for (int i = 0; i < CH; i++) check("t1_wr_per_ch", wr_cnt[i] - wb[i], 3);
    check("t1_done_cnt", done_cnt - d0, 1);

    // Credit stall: ch0 alone, 40 words, nothing popped.
    rst = 1'b1; tick(); rst = 1'b0; tick();
    set_ranges(0, 40, 5, 5, 5, 5, 5, 5);
    base = addr_log.size(); wb = wr_cnt; d0 = done_cnt;
    pulse_start();
    repeat (30) tick();
    check("t2_stall_writes", wr_cnt[0] - wb[0], 16);
    check("t2_stall_busy", 32'(busy), 1);
    check("t2_stall_last_addr", addr_log[addr_log.size()-1], 15);
    manual_rd = 4'b0001;
    tick();
    manual_rd = 4'b0000;
    repeat (10) tick();
    check("t2_one_more_write", wr_cnt[0] - wb[0], 17);
    check("t2_one_more_addr", addr_log[addr_log.size()-1], 16);
    check("t2_other_ch_writes", (wr_cnt[1] - wb[1]) + (wr_cnt[2] - wb[2]) + (wr_cnt[3] - wb[3]), 0);
    check("t2_no_done", done_cnt - d0, 0);
    rst = 1'b1; tick();
    check("t2_abort_busy", 32'(busy), 0);
    rst = 1'b0; tick();

    // Ch1 empty range is skipped; others give two words each.
    set_ranges(100, 102, 200, 200, 300, 302, 400, 402);
    base = addr_log.size(); wb = wr_cnt; d0 = done_cnt;
    pulse_start();
    wait_done(100, k);
    check("t3_done_latency", k, 8);
    repeat (3) tick();
    check("t3_ch1_writes", wr_cnt[1] - wb[1], 0);
    check("t3_nwords", addr_log.size() - base, 6);
    for (int i = 0; i < 6; i++) check("t3_addr", addr_log[base+i], exp_skip[i]);
    check("t3_done_cnt", done_cnt - d0, 1);

    // A second start during RUN, with different ranges, is ignored.
    set_ranges(0, 3, 3, 6, 6, 9, 9, 12);
    base = addr_log.size(); wb = wr_cnt; d0 = done_cnt;
    pulse_start();
    repeat (3) tick();
    set_ranges(50, 60, 70, 80, 90, 95, 20, 30);
    pulse_start();
    wait_done(100, k);
    check("t4_done_latency", k, 10);
    repeat (3) tick();
    check("t4_nwords", addr_log.size() - base, 12);
    for (int i = 0; i < 12; i++) check("t4_addr", addr_log[base+i], exp_rr[i]);
    check("t4_done_cnt", done_cnt - d0, 1);

    // Reset after five issues, then a replay from the start addresses.
    set_ranges(0, 3, 3, 6, 6, 9, 9, 12);
    pulse_start();
    repeat (5) tick();
    check("t5_fifth_addr", 32'(rom_addr), 1);
    rst = 1'b1;
    tick();
    check("t5_rst_rom_addr", 32'(rom_addr), 0);
    check("t5_rst_wr_en", 32'(fifo_wr_en), 0);
    check("t5_rst_busy", 32'(busy), 0);
    check("t5_rst_done", 32'(done), 0);
    rst = 1'b0;
    tick();
    base = addr_log.size(); d0 = done_cnt;
    pulse_start();
    wait_done(100, k);
    check("t5_done_latency", k, 14);
    tick();
    check("t5_nwords", addr_log.size() - base, 12);
    for (int i = 0; i < 12; i++) check("t5_addr", addr_log[base+i], exp_rr[i]);
    check("t5_done_cnt", done_cnt - d0, 1);

    // Steady pop-and-grant on ch0 for 100 words: no stall, no overflow.
    rst = 1'b1; tick(); rst = 1'b0; tick();
    auto_pop = 1'b1;
    set_ranges(0, 100, 8, 8, 8, 8, 8, 8);
    base = addr_log.size(); wb = wr_cnt;
    pulse_start();
    wait_done(400, k);
    check("t6_done_latency", k, 102);
    repeat (3) tick();
    check("t6_writes", wr_cnt[0] - wb[0], 100);
    check("t6_last_addr", addr_log[addr_log.size()-1], 99);
    check("t6_no_overflow", occ_err, 0);
    auto_pop = 1'b0;

    // All ranges empty: straight through to done with no writes.
    set_ranges(7, 7, 7, 7, 7, 7, 7, 7);
    base = addr_log.size(); d0 = done_cnt;
    pulse_start();
    wait_done(50, k);
    check("t7_done_latency", k, 2);
    repeat (3) tick();
    check("t7_no_writes", addr_log.size() - base, 0);
    check("t7_done_cnt", done_cnt - d0, 1);
    check("t7_idle_busy", 32'(busy), 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
